// File: rtl/gpr_file_sb_if.sv
// gpr_file_sb_if: write, reserve and read bundle for the GPR file
// with its busy scoreboard.
interface gpr_file_sb_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic               wa_en;
    logic [AW-1:0]      wa_addr;
    logic [XLEN-1:0]    wa_data;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [XLEN-1:0]    wb_data;
    logic               rsv_en;
    logic [AW-1:0]      rsv_addr;
    logic [NRD-1:0]     rd_en;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]     rd_busy;
    logic               sb_full;

    modport master (
        output wa_en, wa_addr, wa_data,
        output wb_en, wb_addr, wb_data,
        output rsv_en, rsv_addr, rd_en, rd_addr,
        input  rd_data, rd_busy, sb_full
    );

    modport slave (
        input  wa_en, wa_addr, wa_data,
        input  wb_en, wb_addr, wb_data,
        input  rsv_en, rsv_addr, rd_en, rd_addr,
        output rd_data, rd_busy, sb_full
    );
endinterface

// File: rtl/gpr_file_sb.sv
// gpr_file_sb: NRD-read / 2-write register file with per-register busy bits.
// Define GPR_BYPASS_EN to forward same-cycle write data to the read ports.
module gpr_file_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input logic          clk,
    input logic          rst,
    gpr_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            w_wa_hit;
    logic            w_wb_hit;
    logic            w_rsv_hit;
    logic [AW-1:0]   w_ra;

    assign w_wa_hit  = bus.wa_en  && (bus.wa_addr  != '0);
    assign w_wb_hit  = bus.wb_en  && (bus.wb_addr  != '0);
    assign w_rsv_hit = bus.rsv_en && (bus.rsv_addr != '0);

    // Port B is applied after A so it wins; reserve last so it wins over release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wa_hit) begin
                r_regs[bus.wa_addr] <= bus.wa_data;
                r_busy[bus.wa_addr] <= 1'b0;
            end
            if (w_wb_hit) begin
                r_regs[bus.wb_addr] <= bus.wb_data;
                r_busy[bus.wb_addr] <= 1'b0;
            end
            if (w_rsv_hit) begin
                r_busy[bus.rsv_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        w_ra        = '0;
        for (int i = 0; i < NRD; i++) begin
            w_ra = bus.rd_addr[i*AW +: AW];
            if (!rst && bus.rd_en[i] && (w_ra != '0)) begin
                bus.rd_data[i*XLEN +: XLEN] = r_regs[w_ra];
                bus.rd_busy[i]              = r_busy[w_ra];
`ifdef GPR_BYPASS_EN
                // A reservation landing on the same edge keeps the old busy view.
                if (w_wb_hit && (bus.wb_addr == w_ra)) begin
                    bus.rd_data[i*XLEN +: XLEN] = bus.wb_data;
                    bus.rd_busy[i] = (w_rsv_hit && (bus.rsv_addr == w_ra))
                                     ? r_busy[w_ra] : 1'b0;
                end else if (w_wa_hit && (bus.wa_addr == w_ra)) begin
                    bus.rd_data[i*XLEN +: XLEN] = bus.wa_data;
                    bus.rd_busy[i] = (w_rsv_hit && (bus.rsv_addr == w_ra))
                                     ? r_busy[w_ra] : 1'b0;
                end
`endif
            end
        end
    end

    assign bus.sb_full = !rst && (&r_busy[NREG-1:1]);
endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb: directed vectors with a scoreboard queue; a negedge
// monitor pops and checks every expectation pushed for the cycle.
module tb_gpr_file_sb;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = $clog2(NREG);
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string           name;
        int              port;
        logic [XLEN-1:0] d;
        logic            b;
        logic            fchk;
        logic            f;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sbq[$];
    int   n_chk;
    int   n_fail;

    gpr_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

    gpr_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        exp_t e;
        logic [XLEN-1:0] ad;
        while (sbq.size() > 0) begin
            e  = sbq.pop_front();
            ad = bus.rd_data[e.port*XLEN +: XLEN];
            n_chk++;
            if (ad !== e.d) begin
                n_fail++;
                $display("FAIL %s data p%0d got %h want %h", e.name, e.port, ad, e.d);
            end
            n_chk++;
            if (bus.rd_busy[e.port] !== e.b) begin
                n_fail++;
                $display("FAIL %s busy p%0d got %b want %b", e.name, e.port,
                         bus.rd_busy[e.port], e.b);
            end
            if (e.fchk) begin
                n_chk++;
                if (bus.sb_full !== e.f) begin
                    n_fail++;
                    $display("FAIL %s sb_full got %b want %b", e.name, bus.sb_full, e.f);
                end
            end
        end
    end

    task automatic idle();
        bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
        bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0;
        bus.rd_en = '0; bus.rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en[p] = 1'b1;
        bus.rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic wa(input int a, input logic [XLEN-1:0] d);
        bus.wa_en = 1'b1; bus.wa_addr = a[AW-1:0]; bus.wa_data = d;
    endtask

    task automatic wb(input int a, input logic [XLEN-1:0] d);
        bus.wb_en = 1'b1; bus.wb_addr = a[AW-1:0]; bus.wb_data = d;
    endtask

    task automatic rsv(input int a);
        bus.rsv_en = 1'b1; bus.rsv_addr = a[AW-1:0];
    endtask

    task automatic ex(input string n, input int p, input logic [XLEN-1:0] d,
                      input logic b, input logic fchk, input logic f);
        exp_t e;
        e.name = n; e.port = p; e.d = d; e.b = b; e.fchk = fchk; e.f = f;
        sbq.push_back(e);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        rst = 1'b1;
        #1;
        step();
        rd(0, 1);
        ex("rst_comb", 0, '0, 1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b0;

        for (int a = 1; a < NREG; a++) begin
            rd(0, a);
            rd(1, NREG - a);
            ex("rst_p0", 0, '0, 1'b0, 1'b1, 1'b0);
            ex("rst_p1", 1, '0, 1'b0, 1'b0, 1'b0);
            step();
        end

        wa(5, 64'hDEAD_BEEF);
        step();
        rd(0, 5);
        bus.rd_addr[1*AW +: AW] = 5'd5;
        ex("wr_x5", 0, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        ex("rd_dis", 1, '0, 1'b0, 1'b0, 1'b0);
        wb(0, 64'h1234);
        step();
        rd(1, 0);
        ex("wr_x0", 1, '0, 1'b0, 1'b0, 1'b0);
        step();

        wa(7, 64'h11);
        wb(7, 64'h22);
        step();
        rd(0, 7);
        ex("ab_x7", 0, 64'h22, 1'b0, 1'b0, 1'b0);
        step();

        rsv(9);
        step();
        rd(1, 9);
        ex("rsv_x9", 1, '0, 1'b1, 1'b1, 1'b0);
        step();
        wa(9, 64'h55);
        rsv(9);
        step();
        rd(0, 9);
        ex("wr_rsv_x9", 0, 64'h55, 1'b1, 1'b0, 1'b0);
        rsv(9);
        step();
        wa(9, 64'h66);
        step();
        rd(0, 9);
        ex("rel_x9", 0, 64'h66, 1'b0, 1'b0, 1'b0);
        step();

        for (int a = 1; a < NREG; a++) begin
            rsv(a);
            if (a == NREG - 1) begin
                rd(1, NREG - 2);
                ex("pre_full", 1, '0, 1'b1, 1'b1, 1'b0);
            end
            step();
        end
        rd(0, NREG - 1);
        rd(1, 9);
        ex("full_x31", 0, '0, 1'b1, 1'b1, 1'b1);
        ex("full_x9", 1, 64'h66, 1'b1, 1'b0, 1'b0);
        step();

        rst = 1'b1;
        wa(5, 64'h77);
        rsv(4);
        rd(0, 5);
        ex("rst_gate", 0, '0, 1'b0, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        rd(0, 5);
        rd(1, 4);
        ex("rst_x5", 0, '0, 1'b0, 1'b1, 1'b0);
        ex("rst_x4", 1, '0, 1'b0, 1'b0, 1'b0);
        step();
        rd(0, 9);
        ex("rst_x9", 0, '0, 1'b0, 1'b1, 1'b0);
        step();

        wa(3, 64'hAB);
        rd(0, 3);
        ex("byp_a", 0, BYP ? 64'hAB : 64'h0, 1'b0, 1'b0, 1'b0);
        step();
        rd(0, 3);
        rsv(3);
        ex("post_a", 0, 64'hAB, 1'b0, 1'b0, 1'b0);
        step();
        wb(3, 64'hCD);
        rsv(3);
        rd(0, 3);
        ex("byp_rsv", 0, BYP ? 64'hCD : 64'hAB, 1'b1, 1'b0, 1'b0);
        step();
        wa(3, 64'h11);
        wb(3, 64'h22);
        rd(1, 3);
        ex("byp_ab", 1, BYP ? 64'h22 : 64'hCD, BYP ? 1'b0 : 1'b1, 1'b0, 1'b0);
        step();
        rd(0, 3);
        ex("post_ab", 0, 64'h22, 1'b0, 1'b0, 1'b0);
        step();

        for (int k = 0; k < 4 && sbq.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain pending %0d want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
